// File: rtl/if_id_reg.sv
// IF/ID pipeline register for the 5-stage MIPS core. It holds on a load-use
// stall, inserts a NOP bubble on a flush, and keeps saturating perf counters.
module if_id_reg #(
  parameter int          CNT_W    = 32,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lu,
  input  logic             flush,
  input  logic [31:0]      pc_4_in,
  input  logic [31:0]      ir_in,
  input  logic [31:0]      signal_in,
  output logic [31:0]      pc_4_out,
  output logic [31:0]      ir_out,
  output logic [31:0]      signal_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // Flush outranks the stall: the instruction being held is on the wrong path.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_4_out   <= 32'h0;
      ir_out     <= NOP_WORD;
      signal_out <= 32'h0;
      valid_out  <= 1'b0;
    end else if (flush) begin
      pc_4_out   <= 32'h0;
      ir_out     <= NOP_WORD;
      signal_out <= 32'h0;
      valid_out  <= 1'b0;
    end else if (!lu) begin
      pc_4_out   <= pc_4_in;
      ir_out     <= ir_in;
      signal_out <= signal_in;
      valid_out  <= 1'b1;
    end
  end

  // Exactly one counter can advance per cycle, following the same priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      flush_cnt <= sat_inc(flush_cnt);
    end else if (lu) begin
      stall_cnt <= sat_inc(stall_cnt);
    end else begin
      instr_cnt <= sat_inc(instr_cnt);
    end
  end

endmodule

// File: tb/tb_if_id_reg.sv
// Scoreboard bench for if_id_reg: a 32-bit-counter instance and a 4-bit-counter
// instance share the same stimulus and are checked against an event-count model.
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lu = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc_4_in = '0, ir_in = '0, signal_in = '0;

  logic [31:0] pc_a, ir_a, sig_a, pc_b, ir_b, sig_b;
  logic        val_a, val_b;
  logic [31:0] ic_a, sc_a, fc_a;
  logic [3:0]  ic_b, sc_b, fc_b;

  always #5 clk = ~clk;

  if_id_reg #(.CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .lu(lu), .flush(flush),
    .pc_4_in(pc_4_in), .ir_in(ir_in), .signal_in(signal_in),
    .pc_4_out(pc_a), .ir_out(ir_a), .signal_out(sig_a), .valid_out(val_a),
    .instr_cnt(ic_a), .stall_cnt(sc_a), .flush_cnt(fc_a));

  if_id_reg #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .lu(lu), .flush(flush),
    .pc_4_in(pc_4_in), .ir_in(ir_in), .signal_in(signal_in),
    .pc_4_out(pc_b), .ir_out(ir_b), .signal_out(sig_b), .valid_out(val_b),
    .instr_cnt(ic_b), .stall_cnt(sc_b), .flush_cnt(fc_b));

  typedef struct {
    logic [31:0] pc, ir, sig;
    logic        valid;
    longint      n_instr, n_stall, n_flush;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail = 0;

  // Reference state: the instruction visible to decode plus raw event counts.
  logic [31:0] m_pc = '0, m_ir = '0, m_sig = '0;
  logic        m_valid = 1'b0;
  longint      m_instr = 0, m_stall = 0, m_flush = 0;

  function automatic logic [31:0] sat(input longint n, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return 32'(n > lim ? lim : n);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic f,
                      input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] sg);
    exp_t e;
    @(negedge clk);
    rst = r; lu = l; flush = f; pc_4_in = pc; ir_in = ir; signal_in = sg;
    if (r === 1'b1) begin
      m_pc = '0; m_ir = '0; m_sig = '0; m_valid = 1'b0;
      m_instr = 0; m_stall = 0; m_flush = 0;
    end else if (f) begin
      m_pc = '0; m_ir = '0; m_sig = '0; m_valid = 1'b0;
      m_flush++;
    end else if (l) begin
      m_stall++;
    end else begin
      m_pc = pc; m_ir = ir; m_sig = sg; m_valid = 1'b1;
      m_instr++;
    end
    e.pc = m_pc; e.ir = m_ir; e.sig = m_sig; e.valid = m_valid;
    e.n_instr = m_instr; e.n_stall = m_stall; e.n_flush = m_flush;
    exp_q.push_back(e);
  endtask

  task automatic norm(input logic [31:0] pc, input logic [31:0] ir);
    step(1'b0, 1'b0, 1'b0, pc, ir, $urandom);
  endtask

  // Monitor: the register presents a new output every edge, so pop one entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc_4_out", pc_a, e.pc);
        check("ir_out", ir_a, e.ir);
        check("signal_out", sig_a, e.sig);
        check("valid_out", {31'b0, val_a}, {31'b0, e.valid});
        check("instr_cnt32", ic_a, sat(e.n_instr, 32));
        check("stall_cnt32", sc_a, sat(e.n_stall, 32));
        check("flush_cnt32", fc_a, sat(e.n_flush, 32));
        check("data_w4", {pc_b ^ ir_b ^ sig_b, 31'b0, val_b} == {pc_a ^ ir_a ^ sig_a, 31'b0, val_a} ? 32'd1 : 32'd0, 32'd1);
        check("instr_cnt4", {28'b0, ic_b}, sat(e.n_instr, 4));
        check("stall_cnt4", {28'b0, sc_b}, sat(e.n_stall, 4));
        check("flush_cnt4", {28'b0, fc_b}, sat(e.n_flush, 4));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with X inputs, then the plan's reset/load sequence.
    step(1'b1, 1'bx, 1'bx, 'x, 'x, 'x);
    step(1'b1, 1'b0, 1'b0, 'x, 32'h8C010004, 'x);
    norm(32'd4, 32'h8C010004);
    norm(32'd8, 32'h00221820);
    repeat (3) step(1'b0, 1'b1, 1'b0, '1, '1, '1);
    norm(32'd12, 32'h00430820);
    // Flush, then flush with stall, back-to-back flushes, stall inside a bubble.
    step(1'b0, 1'b0, 1'b1, 32'd16, 32'h10000003, $urandom);
    norm(32'd20, 32'h20020005);
    step(1'b0, 1'b1, 1'b1, 32'd24, 32'h08000010, $urandom);
    step(1'b0, 1'b0, 1'b1, 32'd28, 32'h12340000, $urandom);
    step(1'b0, 1'b0, 1'b1, 32'd32, 32'h56780000, $urandom);
    step(1'b0, 1'b1, 1'b0, 32'd36, 32'h9ABC0000, $urandom);
    norm(32'd40, 32'hAC220000);
    // Reset beats stall and flush; next non-reset edge loads normally.
    step(1'b1, 1'b1, 1'b1, 32'd44, 32'hDEADBEEF, $urandom);
    norm(32'd48, 32'h8C010004);
    // Saturation of the 4-bit instance.
    for (int i = 0; i < 20; i++) norm(32'(52 + 4 * i), $urandom);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, $urandom, $urandom, $urandom);
    for (int i = 0; i < 20; i++) step(1'b0, $urandom_range(1), 1'b1, $urandom, $urandom, $urandom);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 30), ($urandom_range(99) < 15),
           $urandom, $urandom, $urandom);
    end
    @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- Pipeline register between the instruction-fetch stage and the decode stage of the 5-stage MIPS core.
- Captures the fetch outputs every cycle: pc_4, ir and the 32-bit stage signal word.
- Holds its contents on a load-use stall and inserts a NOP bubble on a branch/jump flush.
- Keeps saturating performance counters for instructions, stall cycles and flush cycles; the board display logic reads these.

Parameters:
- CNT_W, 32, width of each performance counter.
- NOP_WORD, 32'h00000000, instruction word inserted on flush and reset (sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock, shared with the fetch-stage PC register.
- rst  in  1  synchronous, active-high reset.
- lu  in  1  load-use stall from hazard unit; same signal that freezes the PC.
- flush  in  1  taken branch/jump resolved downstream; squash the instruction being latched.
- pc_4_in  in  32  PC+4 from fetch.
- ir_in  in  32  instruction word from fetch ROM.
- signal_in  in  32  stage signal word from fetch.
- pc_4_out  out  32  registered PC+4 to decode.
- ir_out  out  32  registered instruction to decode.
- signal_out  out  32  registered signal word to decode.
- valid_out  out  1  1 = ir_out is a real fetched instruction; 0 = bubble.
- instr_cnt  out  CNT_W  count of instructions accepted into decode.
- stall_cnt  out  CNT_W  count of stall cycles.
- flush_cnt  out  CNT_W  count of flush cycles.

Behaviour:
- All state updates on the rising edge of clk. Outputs come directly from registers, with no combinational path from inputs to outputs.
- Priority per edge: rst > flush > lu > normal load.
- Reset (rst=1):
  - pc_4_out=0, ir_out=NOP_WORD, signal_out=0, valid_out=0.
  - All counters are 0.
  - rst overrides flush and lu in the same cycle.
  - Reset asserted mid-stall or mid-flush takes effect on that edge. The next edge with rst=0 loads normally.
- Flush (flush=1, rst=0), whatever the value of lu:
  - ir_out=NOP_WORD, pc_4_out=0, signal_out=0, valid_out=0.
  - flush_cnt +1.
  - instr_cnt and stall_cnt do not change.
  - Flush beats stall because the held instruction belongs to the wrong path.
- Stall (lu=1, flush=0, rst=0):
  - All data outputs and valid_out keep their values.
  - stall_cnt +1.
  - A stall during a bubble keeps the bubble (valid_out stays 0).
- Normal (lu=0, flush=0, rst=0):
  - pc_4_out<=pc_4_in, ir_out<=ir_in, signal_out<=signal_in, valid_out<=1.
  - instr_cnt +1.
- Latency: exactly 1 cycle from fetch outputs to decode inputs when there is no stall.
- Counters saturate at all-ones ({CNT_W{1'b1}}) and do not wrap. Each counter increments by at most 1 per cycle.
- Back-to-back flushes each insert a bubble and each count.
- Back-to-back stalls of any length hold indefinitely.
- Inputs equal to X during reset must not propagate to the outputs.

Test Plan:
- Reset: hold rst=1 for 2 cycles with ir_in=32'h8C010004 → ir_out=0, valid_out=0, pc_4_out=0, all counters 0. Release rst with pc_4_in=4 → next edge gives pc_4_out=4, ir_out=32'h8C010004, valid_out=1, instr_cnt=1.
- Stall hold: after loading ir=32'h00221820/pc_4=8, assert lu for 3 cycles while the inputs change to 32'hFFFFFFFF → outputs stay 32'h00221820/8, stall_cnt=3, instr_cnt unchanged. Deassert lu → next input loads.
- Flush: flush=1 for 1 cycle with ir_in=32'h10000003 → ir_out=0, pc_4_out=0, valid_out=0, flush_cnt=1. Next normal cycle gives valid_out=1.
- Flush and stall together: lu=1 and flush=1 on the same edge → bubble inserted, flush_cnt +1, stall_cnt unchanged.
- Reset beats everything: rst=1, lu=1 and flush=1 on the same edge → full reset values, all counters 0.
- Saturation: build with CNT_W=4 and run 20 normal loads → instr_cnt=4'hF and stays there. Repeat with 20 stall cycles → stall_cnt=4'hF.
